// File: rtl/hps_read_data_rx.sv
// Receives words written by the HPS into an output PIO register. A change of bit 31
// marks a new word; its payload is queued in a small FIFO and the toggle is echoed back.
module hps_read_data_rx #(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 31
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [31:0]          pio_word,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 ack_toggle,
   output logic [4:0]           level,
   output logic [15:0]          word_count
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_L = 5'(DEPTH);

   logic [PAYLOAD_W-1:0] mem [DEPTH];
   logic [AW-1:0]        head;
   logic [AW-1:0]        tail;
   logic                 last_toggle;
   logic                 pending;
   logic                 full;
   logic                 push;
   logic                 pop;

   // Output handshake: an entry transfers on a rising edge where out_valid and
   // out_ready are both high; out_valid holds and out_data is stable until then.
   assign pending   = (pio_word[31] != last_toggle);
   assign full      = (level == DEPTH_L);
   assign out_valid = (level != 5'd0);
   assign push      = reset_n && pending && !full;
   assign pop       = reset_n && out_valid && out_ready;
   assign out_data  = mem[head];
   assign ack_toggle = last_toggle;

   // Storage carries no reset; only pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= pio_word[PAYLOAD_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head        <= '0;
         tail        <= '0;
         level       <= 5'd0;
         last_toggle <= 1'b0;
         word_count  <= 16'd0;
      end else begin
         if (push) begin
            tail        <= tail + AW'(1);
            last_toggle <= pio_word[31];
            word_count  <= word_count + 16'd1;
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + 5'd1;
            2'b01:   level <= level - 5'd1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_hps_read_data_rx.sv
// Directed bench for hps_read_data_rx: payloads are queued when driven and
// compared against out_data whenever the DUT hands an entry to the core.
module tb_hps_read_data_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pio_word;
   logic [30:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        ack_toggle;
   logic [4:0]  level;
   logic [15:0] word_count;

   int          total = 0;
   int          bad   = 0;
   logic [30:0] exp_q[$];
   logic        tog;
   logic        ack_before;

   hps_read_data_rx #(.DEPTH(4), .PAYLOAD_W(31)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pio_word   (pio_word),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ack_toggle (ack_toggle),
      .level      (level),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: inspect a pending transfer on the falling edge, then step past the rising edge.
   task automatic tick();
      logic [30:0] exp;
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none", out_data);
         end else begin
            exp = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(exp));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [30:0] payload);
      tog = ~tog;
      pio_word = {tog, payload};
      exp_q.push_back(payload);
   endtask

   initial begin
      reset_n   = 1'b0;
      pio_word  = 32'd0;
      out_ready = 1'b0;
      tog       = 1'b0;
      repeat (3) tick();
      check("rst_level", 32'(level), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ack", 32'(ack_toggle), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle_level", 32'(level), 32'd0);

      // Basic word
      send(31'd5);
      tick();
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_data", 32'(out_data), 32'd5);
      check("basic_ack", 32'(ack_toggle), 32'd1);
      check("basic_level", 32'(level), 32'd1);
      check("basic_count", 32'(word_count), 32'd1);
      repeat (2) tick();
      check("hold_level", 32'(level), 32'd1);
      check("hold_count", 32'(word_count), 32'd1);
      pio_word = {tog, 31'h7};
      tick();
      check("same_tog_level", 32'(level), 32'd1);
      check("same_tog_count", 32'(word_count), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drain_level", 32'(level), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("empty_ready_level", 32'(level), 32'd0);

      // Fill and backpressure
      for (int i = 1; i <= 4; i++) begin
         send(31'(16 + i));
         tick();
      end
      check("fill_level", 32'(level), 32'd4);
      check("fill_ack", 32'(ack_toggle), 32'(tog));
      check("fill_count", 32'(word_count), 32'd5);
      ack_before = tog;
      send(31'h55);
      repeat (2) tick();
      check("full_ack", 32'(ack_toggle), 32'(ack_before));
      check("full_level", 32'(level), 32'd4);
      check("full_count", 32'(word_count), 32'd5);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("full_pop_level", 32'(level), 32'd3);
      check("full_pop_ack", 32'(ack_toggle), 32'(ack_before));
      tick();
      check("late_push_level", 32'(level), 32'd4);
      check("late_push_ack", 32'(ack_toggle), 32'(tog));
      check("late_push_count", 32'(word_count), 32'd6);

      // Simultaneous push and pop at level 2
      out_ready = 1'b1;
      repeat (2) tick();
      out_ready = 1'b0;
      check("pre_sim_level", 32'(level), 32'd2);
      send(31'h66);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("sim_level", 32'(level), 32'd2);
      check("sim_count", 32'(word_count), 32'd7);
      check("sim_head", 32'(out_data), 32'h55);
      out_ready = 1'b1;
      repeat (2) tick();
      check("sim_drain_level", 32'(level), 32'd0);

      // Wrap-around streaming
      for (int i = 1; i <= 10; i++) begin
         send(31'(i));
         tick();
      end
      repeat (2) tick();
      out_ready = 1'b0;
      check("wrap_level", 32'(level), 32'd0);
      check("wrap_count", 32'(word_count), 32'd17);
      check("wrap_queue", 32'(exp_q.size()), 32'd0);

      // Reset mid-stream
      for (int i = 1; i <= 3; i++) begin
         send(31'(32'h30 + i));
         tick();
      end
      check("pre_rst_level", 32'(level), 32'd3);
      reset_n  = 1'b0;
      tog      = 1'b1;
      pio_word = {1'b1, 31'h44};
      exp_q.delete();
      tick();
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1;
      exp_q.push_back(31'h44);
      tick();
      check("post_rst_level", 32'(level), 32'd1);
      check("post_rst_ack", 32'(ack_toggle), 32'd1);
      check("post_rst_count", 32'(word_count), 32'd1);
      check("post_rst_data", 32'(out_data), 32'h44);
      out_ready = 1'b1;
      tick();

      // Counter wrap: bring word_count to 0xFFFF, then one more push
      for (int i = 0; i < 65534; i++) begin
         send(31'($urandom_range(32'h7fff_ffff, 0)));
         tick();
      end
      tick();
      check("pre_wrap_count", 32'(word_count), 32'hffff);
      check("pre_wrap_level", 32'(level), 32'd0);
      out_ready = 1'b0;
      send(31'h77);
      tick();
      check("cnt_wrap_count", 32'(word_count), 32'd0);
      check("cnt_wrap_level", 32'(level), 32'd1);
      check("cnt_wrap_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("final_level", 32'(level), 32'd0);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
